// File: rtl/live_pkg.sv
// Shared types and constants for the live pulse protocol.
// Used by the monitor and by the remote generator.
package live_pkg;

  localparam int LIVE_LEN_W    = 8;
  localparam int TOL_W         = 4;
  localparam int TICK_LOG2_DEF = 23;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // |a - b| formed at 9 bits signed so no wrap can occur
  function automatic logic [LIVE_LEN_W:0] len_delta(
    input logic [LIVE_LEN_W-1:0] a,
    input logic [LIVE_LEN_W-1:0] b
  );
    logic signed [LIVE_LEN_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[LIVE_LEN_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/live_sync.sv
// Multi-stage synchroniser for the asynchronous live line
// with rise/fall detection on the synchronised level.
module live_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   live_s;

  assign live_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= live_s;
    end
  end

  assign rise = live_s & ~prev_q;
  assign fall = ~live_s & prev_q;

endmodule

// File: rtl/live_monitor.sv
// Receiver for the live pulse: measures high time in ticks,
// checks it against the expected length and runs a watchdog.
module live_monitor
  import live_pkg::*;
#(
  parameter int TICK_LOG2   = TICK_LOG2_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_live,
  input  logic [LIVE_LEN_W-1:0] user_length,
  input  logic [TOL_W-1:0]      user_tolerance,
  input  logic [LIVE_LEN_W-1:0] user_timeout,
  output logic [LIVE_LEN_W-1:0] out_length,
  output logic                  out_valid,
  output logic                  out_len_err,
  output logic                  out_timeout,
  output logic                  out_alive
);

  logic                  rise;
  logic                  fall;
  logic [TICK_LOG2-1:0]  pre;
  logic [LIVE_LEN_W-1:0] tick;
  state_t                state;
  logic                  wd_hit;
  logic                  len_err;

  live_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (in_live),
    .rise (rise),
    .fall (fall)
  );

  // The edge cycle is already the first cycle of the new level,
  // so the prescaler restarts at 1 to give floor(cycles/2^TICK_LOG2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      tick <= '0;
    end else if (rise || fall) begin
      pre  <= TICK_LOG2'(1);
      tick <= '0;
    end else begin
      pre <= pre + 1'b1;
      if (&pre && !(&tick))
        tick <= tick + 1'b1;
    end
  end

  assign wd_hit = (state != ST_WAIT)
               && (user_timeout != '0)
               && (tick >= user_timeout);

  assign len_err = len_delta(tick, user_length)
                 > {{(LIVE_LEN_W+1-TOL_W){1'b0}}, user_tolerance};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT;
      out_length  <= '0;
      out_valid   <= 1'b0;
      out_len_err <= 1'b0;
      out_timeout <= 1'b0;
      out_alive   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_WAIT: begin
          if (rise)
            state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (fall) begin
            out_length  <= tick;
            out_len_err <= len_err;
            out_valid   <= 1'b1;
            out_timeout <= out_timeout | wd_hit;
            out_alive   <= !len_err && !(out_timeout || wd_hit);
            state       <= ST_LOW;
          end else if (wd_hit) begin
            out_timeout <= 1'b1;
            out_alive   <= 1'b0;
          end
        end
        ST_LOW: begin
          if (rise) begin
            out_timeout <= 1'b0;
            state       <= ST_HIGH;
          end else if (wd_hit) begin
            out_timeout <= 1'b1;
            out_alive   <= 1'b0;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_live_monitor.sv
// Scoreboard bench for live_monitor: random pulses checked
// against an arithmetic model of the pulse measurement.
module tb_live_monitor;

  localparam int TL   = 4;
  localparam int TICK = 1 << TL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_live = 1'b0;
  logic [7:0] user_length = '0;
  logic [3:0] user_tolerance = '0;
  logic [7:0] user_timeout = '0;
  logic [7:0] out_length;
  logic       out_valid;
  logic       out_len_err;
  logic       out_timeout;
  logic       out_alive;

  live_monitor #(
    .TICK_LOG2  (TL),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_live       (in_live),
    .user_length   (user_length),
    .user_tolerance(user_tolerance),
    .user_timeout  (user_timeout),
    .out_length    (out_length),
    .out_valid     (out_valid),
    .out_len_err   (out_len_err),
    .out_timeout   (out_timeout),
    .out_alive     (out_alive)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int len;
    int err;
    int alive;
    int at;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   t_rise = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: length is whole ticks of high time, watchdog fires
  // once the high time covers user_timeout ticks.
  function automatic exp_t model(input int nh);
    exp_t e;
    int   d;
    e.len = nh / TICK;
    if (e.len > 255) e.len = 255;
    d = e.len - int'(user_length);
    if (d < 0) d = -d;
    e.err = (d > int'(user_tolerance)) ? 1 : 0;
    e.alive = (e.err == 0 && !(user_timeout != 0
               && nh >= TICK * int'(user_timeout))) ? 1 : 0;
    e.at = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", cyc, e.at);
        chk("out_length", int'(out_length), e.len);
        chk("out_len_err", int'(out_len_err), e.err);
        chk("out_alive", int'(out_alive), e.alive);
      end
    end
  end

  task automatic go_high();
    @(posedge clk);
    #1 in_live = 1'b1;
    t_rise = cyc;
  endtask

  task automatic go_low();
    exp_t e;
    in_live = 1'b0;
    e = model(cyc - t_rise);
    e.at = cyc + 3;
    q.push_back(e);
  endtask

  task automatic pulse(input int nh, input int nl);
    go_high();
    repeat (nh) @(posedge clk);
    #1 go_low();
    repeat (nl) @(posedge clk);
  endtask

  task automatic set_par(input int l, input int t, input int to);
    user_length    = 8'(l);
    user_tolerance = 4'(t);
    user_timeout   = 8'(to);
  endtask

  function automatic int all_out();
    return int'({out_length, out_valid, out_len_err, out_timeout, out_alive});
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nh;
    int nl;
    int ul;
    int to;

    set_par(5, 0, 10);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 in_live = ~in_live;
      @(negedge clk);
      chk("reset_outputs", all_out(), 0);
    end
    in_live = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1 chk("wait_no_timeout", int'(out_timeout), 0);
    chk("wait_outputs", all_out(), 0);

    set_par(5, 0, 0);
    pulse(80, 20);

    set_par(5, 1, 0);
    pulse(48, 20);
    pulse(80, 20);

    set_par(5, 1, 10);
    pulse(80, 200);
    #1 chk("low_timeout", int'(out_timeout), 1);
    chk("low_timeout_alive", int'(out_alive), 0);
    go_high();
    repeat (4) @(posedge clk);
    #1 chk("rise_clears_timeout", int'(out_timeout), 0);
    repeat (76) @(posedge clk);
    #1 go_low();
    repeat (20) @(posedge clk);

    set_par(5, 1, 10);
    go_high();
    repeat (200) @(posedge clk);
    #1 chk("high_timeout", int'(out_timeout), 1);
    chk("high_timeout_alive", int'(out_alive), 0);
    repeat (100) @(posedge clk);
    #1 go_low();
    repeat (20) @(posedge clk);

    set_par(255, 0, 0);
    pulse(4200, 20);

    for (int i = 0; i < 30; i++) begin
      nh = $urandom_range(700, 1);
      nl = $urandom_range(60, 5);
      to = ($urandom_range(1, 0) == 1) ? $urandom_range(40, 1) : 0;
      if (to != 0 && nh > TICK * to - 4 && nh < TICK * to + 4)
        nh = nh + 8;
      if ($urandom_range(1, 0) == 1) begin
        ul = nh / TICK + $urandom_range(6, 0) - 3;
        if (ul < 0) ul = 0;
      end else begin
        ul = $urandom_range(40, 0);
      end
      set_par(ul, $urandom_range(15, 0), to);
      pulse(nh, nl);
    end

    set_par(5, 0, 0);
    go_high();
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_out(), 0);
    in_live = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    pulse(80, 20);

    repeat (10) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/live_monitor.md
Name: live_monitor

Overview:
- Receiving end of the "live" pulse protocol. A remote generator drives in_live high for user_length ticks after each start; 1 tick = 2^TICK_LOG2 clk cycles.
- This block synchronises in_live and measures each high pulse in ticks. It checks each pulse against the expected length and tolerance.
- A watchdog flags loss of heartbeat when the line is stuck high or stuck low.
- Status outputs feed the top-level trigger/veto logic.

Parameters:
- TICK_LOG2, 23, log2 of clk cycles per tick; must match the generator (set to 4 in simulation).
- SYNC_STAGES, 2, flip-flop stages in the in_live synchroniser (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_live  input  1  asynchronous live pulse from the remote generator
- user_length  input  8  expected high length in ticks
- user_tolerance  input  4  allowed |measured - expected| in ticks
- user_timeout  input  8  watchdog limit in ticks; 0 disables the watchdog
- out_length  output  8  last measured high length in ticks, saturating at 255
- out_valid  output  1  one-cycle strobe when out_length/out_len_err update
- out_len_err  output  1  last pulse was outside tolerance
- out_timeout  output  1  watchdog expired
- out_alive  output  1  last pulse was in tolerance and no timeout is pending

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs are 0; state is WAIT.
  - Synchroniser, prescaler and tick counter are cleared.
  - Reset asserted mid-pulse discards the measurement in progress.
- Synchroniser and edge detect:
  - in_live passes through SYNC_STAGES flops to give live_s; rise/fall = live_s vs its 1-cycle-delayed copy.
  - Rise and fall never occur in the same cycle.
- Prescaler:
  - TICK_LOG2-bit free counter, cleared on every rise or fall.
  - Its wrap increments an 8-bit tick counter, which saturates at 255.
  - The tick counter is cleared on every rise or fall.
  - Measured length = floor(cycles_high / 2^TICK_LOG2).
- FSM states: WAIT, HIGH, LOW.
  - WAIT: no watchdog. On rise: clear counters, go to HIGH.
  - HIGH:
    - On fall: latch out_length = tick count and set out_len_err = (|tick - user_length| > user_tolerance).
    - Same cycle: pulse out_valid for 1 cycle; out_alive = !out_len_err && !out_timeout. Go to LOW.
  - LOW: on rise, clear out_timeout, clear counters, go to HIGH. out_length/out_len_err hold.
  - Watchdog (HIGH or LOW, user_timeout != 0):
    - When the tick count reaches user_timeout, set out_timeout=1 and out_alive=0.
    - Stay in the current state; out_timeout is sticky until the next rise.
    - Stuck-high: the eventual fall still reports the length and keeps out_alive=0.
- Latency: in_live fall to out_valid = SYNC_STAGES+1 clk cycles.
- Arithmetic:
  - The difference is computed at 9 bits signed, then absolute value, then compared against zero-extended user_tolerance.
  - user_length, user_tolerance and user_timeout are sampled live, not latched.

Decomposition:
- Package live_pkg:
  - State enum (WAIT/HIGH/LOW, 2 bits).
  - LIVE_LEN_W=8 and TOL_W=4 width constants.
  - Default TICK_LOG2, shared with live_generator.
- Sub-module live_sync: SYNC_STAGES synchroniser plus rise/fall edge detector.
- The FSM, prescaler and checker stay in live_monitor.

Test Plan (TICK_LOG2=4, tick=16 cycles):
- Reset held, in_live toggling -> all outputs 0; after release with in_live low, the block stays in WAIT and out_timeout remains 0 indefinitely.
- user_length=5, tol=0, high 80 cycles -> out_valid 3 cycles after the fall; out_length=5, out_len_err=0, out_alive=1.
- user_length=5, tol=1, high 48 cycles -> out_length=3, out_len_err=1, out_alive=0; a following 80-cycle pulse gives err=0, alive=1.
- user_timeout=10 after a good pulse, in_live low 200 cycles -> out_timeout=1 at low tick 10, out_alive=0; the next rise clears out_timeout.
- user_timeout=10, user_length=5, high 300 cycles -> out_timeout=1 mid-pulse; on the fall out_length=18, out_len_err=1, out_alive=0.
- rst_n pulsed low mid-HIGH -> outputs 0 immediately, no out_valid; the next 80-cycle pulse reports out_length=5 correctly.
